// File: rtl/note_player_if.sv
// Note-fetch handshake between the sequencer (master) and the note player (slave).
interface note_player_if #(
    parameter int unsigned NOTE_W = 6,
    parameter int unsigned DUR_W  = 6
);
    logic              new_note;
    logic [NOTE_W-1:0] note_in;
    logic [DUR_W-1:0]  duration_in;
    logic              note_done;

    modport master (
        output new_note,
        output note_in,
        output duration_in,
        input  note_done
    );

    modport slave (
        input  new_note,
        input  note_in,
        input  duration_in,
        output note_done
    );
endinterface

// File: rtl/note_player.sv
// Plays one note at a time: times its duration in beats while driving a square-wave tone
// whose half-period is looked up from an external ROM addressed by note_out.
module note_player #(
    parameter int unsigned NOTE_W = 6,
    parameter int unsigned DUR_W  = 6,
    parameter int unsigned HP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              beat,
    input  logic [HP_W-1:0]   half_period,
    note_player_if.slave      seq,
    output logic [NOTE_W-1:0] note_out,
    output logic              tone_out,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StPlaying, StDone} state_e;

    state_e            state_q, state_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [DUR_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [HP_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic              tone_q, tone_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            note_q     <= '0;
            dur_q      <= '0;
            beat_cnt_q <= '0;
            tone_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            beat_cnt_q <= beat_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        note_d     = note_q;
        dur_d      = dur_q;
        beat_cnt_d = beat_cnt_q;
        tone_cnt_d = tone_cnt_q;
        tone_d     = tone_q;
        unique case (state_q)
            StIdle: begin
                if (seq.new_note && play) begin
                    note_d     = seq.note_in;
                    dur_d      = seq.duration_in;
                    beat_cnt_d = '0;
                    tone_cnt_d = '0;
                    tone_d     = 1'b0;
                    state_d    = (seq.duration_in != '0) ? StPlaying : StDone;
                end
            end
            StPlaying: begin
                if (!play) begin
                    state_d = StIdle;
                    tone_d  = 1'b0;
                end else begin
                    if (note_q == '0 || half_period == '0) begin
                        tone_cnt_d = '0;
                        tone_d     = 1'b0;
                    end else if (tone_cnt_q == half_period - HP_W'(1)) begin
                        tone_cnt_d = '0;
                        tone_d     = ~tone_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + HP_W'(1);
                    end
                    // Silence on the way into DONE overrides any toggle due on the same edge.
                    if (beat) begin
                        if (beat_cnt_q == dur_q - DUR_W'(1)) begin
                            state_d = StDone;
                            tone_d  = 1'b0;
                        end else begin
                            beat_cnt_d = beat_cnt_q + DUR_W'(1);
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                tone_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    assign note_out      = note_q;
    assign tone_out      = tone_q;
    assign busy          = (state_q == StPlaying);
    assign seq.note_done = (state_q == StDone);

endmodule

// File: doc/note_player.md
# note_player

Consumer end of the note-fetch handshake. It accepts a note and duration on a one-cycle `new_note` strobe, times the duration in beat ticks, and meanwhile drives a square-wave tone whose half-period comes from an external frequency ROM addressed by the latched note. When the duration expires it returns a one-cycle `note_done` pulse, so the sequencer can fetch the next note.

## Interface
- `NOTE_W`, default 6: note code width; code 0 = rest.
- `DUR_W`, default 6: duration width, in beats.
- `HP_W`, default 16: half-period width, in clk cycles.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `play`  in  1  level enable; low aborts any note.
- `new_note`  in  1  one-cycle strobe; `note_in`/`duration_in` valid in the same cycle.
- `note_in`  in  NOTE_W  note code.
- `duration_in`  in  DUR_W  note length in beats.
- `beat`  in  1  one-cycle beat tick, free-running.
- `half_period`  in  HP_W  combinational ROM data for address `note_out`.
- `note_out`  out  NOTE_W  latched note; this is the ROM address.
- `tone_out`  out  1  square-wave audio.
- `busy`  out  1  high while in PLAYING.
- `note_done`  out  1  one-cycle pulse at note end.

## Operation
- Clock and reset: one clock `clk`. `reset` is asynchronous and active-high.
- Registered values on reset: state=IDLE, `note_out`=0, `tone_out`=0, `note_done`=0, `busy`=0, beat count=0, tone count=0.
- IDLE:
  - `new_note`&`play` latches `note_in`→`note_out` and `duration_in`→dur_reg.
  - It also clears beat count and tone count, and sets `tone_out`=0.
  - Next state is PLAYING if `duration_in`≠0, otherwise DONE.
  - `new_note` with `play` low is ignored.
- PLAYING:
  - `busy`=1.
  - Each `beat` increments beat count.
  - A `beat` with beat count == dur_reg−1 moves to DONE.
  - `new_note` is ignored.
- DONE: `note_done`=1 for exactly this one cycle. `tone_out` is forced to 0. Next state is IDLE unconditionally.
- Abort: `play` low in PLAYING or DONE moves to IDLE at the next edge.
  - `note_done` is not pulsed for an aborted note.
  - `tone_out`→0. `note_out` holds its value.
- Tone generator (PLAYING only):
  - If `note_out`=0 or `half_period`=0 (rest): `tone_out`=0 and the tone count holds at 0.
  - Otherwise the tone count increments every clk. At count == `half_period`−1 it wraps to 0 and `tone_out` toggles.
  - Output period is 2·`half_period` clk cycles.
- Arithmetic: beat count is DUR_W bits and tone count is HP_W bits, both unsigned. Neither can overflow, because they wrap or terminate before the maximum.

## Timing
- Load latency: `new_note` sampled at edge k → `note_out` and `busy` valid after edge k.
- Beat alignment: a `beat` coincident with the load edge k is not counted.
- Duration: D≥1 beats. The edge sampling the D-th counted beat enters DONE, and `note_done` is high for the following cycle.
- Zero duration: D=0 gives `note_done` one cycle after the load edge, with no tone.
- Tone phase: first toggle `half_period` cycles after the load edge, i.e. at edge k+`half_period`.
- Back-to-back: after `note_done`, the block is in IDLE and accepts `new_note` on the very next cycle. The upstream fetcher issues NEW_NOTE two cycles after sampling `note_done`; this block supports any gap ≥1 cycle.
- Abort during DONE: `play` falling in the DONE cycle still lets that `note_done` pulse complete, because it is already registered. The return to IDLE is identical.
- Async reset: asserted mid-note, all outputs reach their reset values immediately, with no `note_done` pulse.
- Release: first state update on the first clk edge after deassertion.

## Test plan
- Basic note: play=1, new_note with note_in=5, duration_in=3, half_period=4, beat every 20 cycles.
  - `tone_out` toggles every 4 cycles.
  - `note_done` is a single-cycle pulse in the cycle after the 3rd beat edge; `busy` drops at the same time.
- Rest and zero duration:
  - note_in=0, duration_in=2: `tone_out` stays 0 throughout; `note_done` after the 2nd beat.
  - duration_in=0: `note_done` one cycle after load; `busy` never set.
- Abort: play deasserted mid-note (duration 4, after the 2nd beat) → IDLE next edge, `tone_out`=0, no `note_done` pulse ever.
- Simultaneous events:
  - `beat` coincident with the load cycle is not counted (duration 1 still needs one later beat).
  - new_note during PLAYING is ignored: `note_out` unchanged, done timing unchanged.
- Handshake loop: connect to the note-fetch sequencer with a 3-note stub ROM (durations 1, 2, 1). Check:
  - three `note_done` pulses;
  - `note_out` sequence matches the ROM;
  - no lost or duplicated notes.
- Async reset: assert reset between clk edges mid-tone → `tone_out`, `busy`, `note_done`, `note_out` read 0 before the next edge. After release, a new note plays normally.
